// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost exit monitor: FSM states,
// failure reason codes and the exit-flag bit position.
package tohost_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      PASS  = 2'd2,
      FAIL  = 2'd3
   } state_e;

   localparam logic [1:0] REASON_NONE     = 2'd0;
   localparam logic [1:0] REASON_EXITCODE = 2'd1;
   localparam logic [1:0] REASON_HANG     = 2'd2;
   localparam logic [1:0] REASON_BADWRITE = 2'd3;

   localparam int         EXIT_BIT  = 0;
   localparam logic [7:0] FULL_STRB = 8'hFF;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/tohost_exit_monitor_if.sv
// Write-request channel snooped by the exit monitor; the producer drives
// the request fields, the monitor answers with wr_ready.
interface tohost_exit_monitor_if #(
   parameter int ADDR_W = 32
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [63:0]       wr_data;
   logic [7:0]        wr_strb;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_strb,
      input  wr_ready
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_strb,
      output wr_ready
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count
);
   logic [W-1:0] count_reg;
   logic [W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = '0;
      end else if (enable && (count_reg != {W{1'b1}})) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;
endmodule

// File: rtl/tohost_exit_monitor.sv
// Decodes writes to the tohost word into a sticky pass/fail verdict, with a
// drain delay before exit verdicts and a hang watchdog while the program runs.
module tohost_exit_monitor
   import tohost_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h8000_1000,
   parameter int                DRAIN_CYCLES = 16,
   parameter int                WATCHDOG     = 1_000_000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   tohost_exit_monitor_if.slave  wr,
   input  logic                  hb,
   output logic                  io_success,
   output logic                  io_failure,
   output logic [62:0]           exit_code,
   output logic [1:0]            fail_reason,
   output logic [63:0]           cycle_count
);
   localparam int WD_W = cnt_width(WATCHDOG);
   localparam int DR_W = cnt_width(DRAIN_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST    = WD_W'((WATCHDOG > 0) ? WATCHDOG - 1 : 0);
   localparam logic [DR_W-1:0] DRAIN_LOAD = DR_W'(DRAIN_CYCLES);

   state_e          state_reg, state_next;
   logic [DR_W-1:0] drain_reg, drain_next;
   logic [62:0]     exit_code_reg, exit_code_next;
   logic [1:0]      reason_reg, reason_next;
   logic            pending_pass_reg, pending_pass_next;

   logic [WD_W-1:0] wd_count;
   logic            wr_fire;
   logic            tohost_hit;
   logic            wd_clear;
   logic            wd_expire;

   // Never back-pressure the producer, whatever the verdict state.
   assign wr.wr_ready = 1'b1;
   assign wr_fire     = wr.wr_valid;
   assign tohost_hit  = wr_fire && (wr.wr_addr == TOHOST_ADDR);
   assign wd_clear    = hb || wr_fire;

   // Expiry is the edge on which the idle count would reach WATCHDOG; any
   // activity in that same cycle pre-empts it.
   assign wd_expire = (WATCHDOG > 0) && (state_reg == RUN) && !wd_clear &&
                      (wd_count == WD_LAST);

   sat_counter #(.W(64)) u_cycle_count (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (1'b0),
      .enable  (1'b1),
      .count   (cycle_count)
   );

   sat_counter #(.W(WD_W)) u_watchdog (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (wd_clear),
      .enable  (state_reg == RUN),
      .count   (wd_count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= RUN;
         drain_reg        <= '0;
         exit_code_reg    <= '0;
         reason_reg       <= REASON_NONE;
         pending_pass_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         drain_reg        <= drain_next;
         exit_code_reg    <= exit_code_next;
         reason_reg       <= reason_next;
         pending_pass_reg <= pending_pass_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      drain_next        = drain_reg;
      exit_code_next    = exit_code_reg;
      reason_next       = reason_reg;
      pending_pass_next = pending_pass_reg;
      unique case (state_reg)
         RUN: begin
            if (tohost_hit) begin
               if (wr.wr_strb != FULL_STRB) begin
                  state_next  = FAIL;
                  reason_next = REASON_BADWRITE;
               end else if (wr.wr_data != 64'd0) begin
                  if (wr.wr_data[EXIT_BIT]) begin
                     state_next        = DRAIN;
                     drain_next        = DRAIN_LOAD;
                     exit_code_next    = wr.wr_data[63:1];
                     pending_pass_next = (wr.wr_data[63:1] == 63'd0);
                  end else begin
                     // Even nonzero values are syscall requests, which this harness cannot serve.
                     state_next  = FAIL;
                     reason_next = REASON_BADWRITE;
                  end
               end
            end else if (wd_expire) begin
               state_next  = FAIL;
               reason_next = REASON_HANG;
            end
         end
         DRAIN: begin
            if (drain_reg == '0) begin
               if (pending_pass_reg) begin
                  state_next = PASS;
               end else begin
                  state_next  = FAIL;
                  reason_next = REASON_EXITCODE;
               end
            end else begin
               drain_next = drain_reg - 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      io_success = 1'b0;
      io_failure = 1'b0;
      case (state_reg)
         PASS:    io_success = 1'b1;
         FAIL:    io_failure = 1'b1;
         default: begin
         end
      endcase
   end

   assign exit_code   = exit_code_reg;
   assign fail_reason = reason_reg;
endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Scoreboard bench for tohost_exit_monitor: stimulus predicts each verdict
// into a queue, a negedge monitor pops and compares when io_* first rises.
`timescale 1ns/1ps
module tb_tohost_exit_monitor;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] TOHOST = 32'h8000_1000;
   localparam int          DRAIN  = 16;
   localparam int          WD     = 100;
   localparam logic [1:0]  R_NONE = 2'd0;
   localparam logic [1:0]  R_EXIT = 2'd1;
   localparam logic [1:0]  R_HANG = 2'd2;
   localparam logic [1:0]  R_BAD  = 2'd3;

   typedef struct {
      bit          pass;
      logic [62:0] code;
      logic [1:0]  reason;
      int          cyc;
   } verdict_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        hb;
   logic        io_success;
   logic        io_failure;
   logic [62:0] exit_code;
   logic [1:0]  fail_reason;
   logic [63:0] cycle_count;

   tohost_exit_monitor_if #(.ADDR_W(ADDR_W)) wr_if ();

   tohost_exit_monitor #(
      .ADDR_W       (ADDR_W),
      .TOHOST_ADDR  (TOHOST),
      .DRAIN_CYCLES (DRAIN),
      .WATCHDOG     (WD)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .wr          (wr_if),
      .hb          (hb),
      .io_success  (io_success),
      .io_failure  (io_failure),
      .exit_code   (exit_code),
      .fail_reason (fail_reason),
      .cycle_count (cycle_count)
   );

   always #5 clock = ~clock;

   int       tb_cycle = 0;
   int       errors   = 0;
   int       checks   = 0;
   verdict_t exp_q[$];
   verdict_t mon_v;
   bit       m_decided;
   int       m_last_act;
   bit       last_pass_exp;
   bit       seen;
   bit       armed = 1'b0;

   // Cycles since reset release, kept independently of the DUT.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) tb_cycle <= 0;
      else          tb_cycle <= tb_cycle + 1;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h required=0x%0h (cycle %0d)", name, got, exp, tb_cycle);
      end
   endtask

   always @(negedge clock) begin
      if (armed && reset_n && !seen && (io_success || io_failure)) begin
         seen = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_verdict: got success=%0b failure=%0b at cycle %0d, required no verdict",
                     io_success, io_failure, tb_cycle);
         end else begin
            mon_v = exp_q.pop_front();
            $display("verdict: cycle=%0d success=%0b failure=%0b exit_code=%0d reason=%0d",
                     tb_cycle, io_success, io_failure, exit_code, fail_reason);
            check("io_success", io_success, mon_v.pass);
            check("io_failure", io_failure, !mon_v.pass);
            check("exit_code", exit_code, mon_v.code);
            check("fail_reason", fail_reason, mon_v.reason);
            check("verdict_cycle", 64'(tb_cycle), 64'(mon_v.cyc));
            check("cycle_count", cycle_count, 64'(tb_cycle));
         end
      end
   end

   task automatic expect_verdict(input bit pass, input logic [62:0] code,
                                 input logic [1:0] reason, input int cyc);
      verdict_t v;
      v.pass   = pass;
      v.code   = code;
      v.reason = reason;
      v.cyc    = cyc;
      exp_q.push_back(v);
      m_decided     = 1'b1;
      last_pass_exp = pass;
   endtask

   // One clock cycle of stimulus; the reference rules run on what is driven.
   task automatic drive_cycle(input bit valid, input logic [31:0] addr, input logic [63:0] data,
                              input logic [7:0] strb, input bit beat);
      int c;
      c = tb_cycle;
      wr_if.wr_valid = valid;
      wr_if.wr_addr  = addr;
      wr_if.wr_data  = data;
      wr_if.wr_strb  = strb;
      hb             = beat;
      if (!m_decided) begin
         if (valid && addr == TOHOST) begin
            if (strb != 8'hFF) begin
               expect_verdict(1'b0, 63'd0, R_BAD, c + 1);
            end else if (data != 64'd0) begin
               if (data[0]) begin
                  // accepted at the next edge, then DRAIN+1 further edges
                  expect_verdict(data[63:1] == 63'd0, data[63:1],
                                 (data[63:1] == 63'd0) ? R_NONE : R_EXIT, (c + 1) + (DRAIN + 1));
               end else begin
                  expect_verdict(1'b0, 63'd0, R_BAD, c + 1);
               end
            end
         end else if (!(valid || beat) && (c - m_last_act) == WD) begin
            expect_verdict(1'b0, 63'd0, R_HANG, c + 1);
         end
         if (valid || beat) m_last_act = c;
      end
      if (valid) begin
         $display("write: cycle=%0d addr=0x%h data=0x%h strb=0x%h", c, addr, data, strb);
         check("wr_ready", wr_if.wr_ready, 64'd1);
      end
      @(posedge clock);
      #1;
      wr_if.wr_valid = 1'b0;
      hb             = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(1'b0, 32'd0, 64'd0, 8'd0, 1'b0);
   endtask

   task automatic idle_until(input int cyc);
      while (tb_cycle < cyc) drive_cycle(1'b0, 32'd0, 64'd0, 8'd0, 1'b0);
   endtask

   task automatic tohost_write(input logic [63:0] data, input logic [7:0] strb);
      drive_cycle(1'b1, TOHOST, data, strb, 1'b0);
   endtask

   task automatic wait_verdict(input int budget);
      int n;
      n = 0;
      while (!(m_decided && exp_q.size() == 0) && n < budget) begin
         idle(1);
         n++;
      end
      checks++;
      if (!(m_decided && exp_q.size() == 0)) begin
         errors++;
         $display("FAIL verdict_timeout: got no verdict within %0d cycles, required one (cycle %0d)",
                  budget, tb_cycle);
      end
   endtask

   task automatic check_sticky();
      idle(3);
      check("sticky_success", io_success, last_pass_exp);
      check("sticky_failure", io_failure, !last_pass_exp);
   endtask

   // Asynchronous assert mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      m_decided  = 1'b0;
      m_last_act = -1;
      seen       = 1'b0;
      wr_if.wr_valid = 1'b0;
      hb             = 1'b0;
      #1;
      check("rst_io_success", io_success, 64'd0);
      check("rst_io_failure", io_failure, 64'd0);
      check("rst_exit_code", exit_code, 64'd0);
      check("rst_fail_reason", fail_reason, 64'd0);
      check("rst_cycle_count", cycle_count, 64'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no end of test, required finish (cycle %0d)", tb_cycle);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [63:0] data;
      logic [7:0]  strb;
      int          c0;
      int          pre;
      int          hb_on;
      int          kind;
      int          r;

      reset_n        = 1'b1;
      hb             = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_addr  = '0;
      wr_if.wr_data  = '0;
      wr_if.wr_strb  = '0;
      @(posedge clock);
      #1;
      do_reset();
      armed = 1'b1;

      // Plain pass.
      idle(4);
      tohost_write(64'h1, 8'hFF);
      wait_verdict(40);
      check_sticky();

      // Nonzero exit code; a later exit write during drain is ignored.
      do_reset();
      idle(3);
      tohost_write(64'h2B, 8'hFF);
      idle(4);
      tohost_write(64'h1, 8'hFF);
      wait_verdict(40);
      check_sticky();

      // Hang with no activity at all.
      do_reset();
      wait_verdict(300);
      check_sticky();

      // Heartbeat on the last idle cycle restarts the full window.
      do_reset();
      idle_until(99);
      drive_cycle(1'b0, 32'd0, 64'd0, 8'd0, 1'b1);
      wait_verdict(300);
      check_sticky();

      // Neighbouring address is harmless; partial strobe to tohost fails at once.
      do_reset();
      idle(3);
      drive_cycle(1'b1, TOHOST + 32'd8, 64'h1, 8'hFF, 1'b0);
      idle(2);
      check("neighbour_no_success", io_success, 64'd0);
      check("neighbour_no_failure", io_failure, 64'd0);
      tohost_write(64'h1, 8'h0F);
      wait_verdict(10);
      check_sticky();

      // Reset while the drain counter holds 5 discards the pending pass.
      do_reset();
      idle(2);
      c0 = tb_cycle;
      tohost_write(64'h1, 8'hFF);
      idle_until(c0 + 12);
      do_reset();
      idle(DRAIN + 10);
      check("postrst_no_success", io_success, 64'd0);
      check("postrst_no_failure", io_failure, 64'd0);
      tohost_write(64'h1, 8'hFF);
      wait_verdict(40);
      check_sticky();

      // Exit write lands on the watchdog expiry cycle.
      do_reset();
      idle_until(99);
      tohost_write(64'h1, 8'hFF);
      wait_verdict(40);
      check_sticky();

      // Randomized runs: background traffic and heartbeats, then one tohost write.
      for (int it = 0; it < 10; it++) begin
         pre   = $urandom_range(0, 150);
         hb_on = $urandom_range(0, 1);
         kind  = $urandom_range(0, 3);
         do_reset();
         for (int k = 0; k < pre; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0)
               drive_cycle(1'b1, TOHOST + 32'(8 * $urandom_range(1, 4)), {$urandom, $urandom}, 8'hFF, 1'b0);
            else if (r == 1)
               tohost_write(64'd0, 8'hFF);
            else
               drive_cycle(1'b0, 32'd0, 64'd0, 8'd0, (hb_on != 0) && (r < 5));
         end
         strb = 8'hFF;
         case (kind)
            0:       data = 64'h1;
            1:       data = {$urandom, $urandom} | 64'h3;
            2:       data = ({$urandom, $urandom} | 64'h2) & ~64'h1;
            default: begin
               data = {$urandom, $urandom};
               strb = 8'($urandom_range(0, 254));
            end
         endcase
         tohost_write(data, strb);
         wait_verdict(300);
         check_sticky();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
